cmd_dispatch: RTL and testbench

Command dispatcher sitting directly downstream of the UART command wrapper and upstream of the flight controller and inertial integrator. It consumes assembled 24-bit host commands (8-bit opcode plus 16-bit data), updates the desired-attitude and thrust setpoint registers, and sequences calibration: motor spin-up delay, a calibration start strobe, then waiting for completion. It requests one response byte per accepted command (ACK `8'hA5`, NAK `8'hEE`).

---
 rtl/quad_cmd_pkg.sv | 24 ++
 rtl/cmd_dispatch_if.sv | 12 +
 rtl/cal_tmr.sv | 37 +++
 rtl/cmd_dispatch.sv | 139 +++++++++++++
 tb/tb_cmd_dispatch.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/quad_cmd_pkg.sv
// Shared opcode, response and dispatcher state definitions for the quad command path.
// Used by the UART wrapper, the command dispatcher and their testbenches.
package quad_cmd_pkg;

  typedef enum logic [7:0] {
    SET_PITCH  = 8'h02,
    SET_ROLL   = 8'h03,
    SET_YAW    = 8'h04,
    SET_THRST  = 8'h05,
    CALIBRATE  = 8'h06,
    E_LAND     = 8'h07,
    MOTORS_OFF = 8'h08
  } cmd_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPINUP = 2'd1,
    CAL    = 2'd2
  } disp_state_t;

endpackage

// File: rtl/cmd_dispatch_if.sv
// Command handshake between the UART command wrapper (master) and the dispatcher (slave).
interface cmd_dispatch_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (output cmd_rdy, cmd, data, input clr_cmd_rdy, send_resp, resp);
  modport slave  (input cmd_rdy, cmd, data, output clr_cmd_rdy, send_resp, resp);
endinterface

// File: rtl/cal_tmr.sv
// Spin-up delay counter: synchronous clear wins over enable; full when every bit is set.
module cal_tmr #(
  parameter int W = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic full_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign full_o = &cnt_q;

endmodule

// File: rtl/cmd_dispatch.sv
// Host command dispatcher: updates attitude/thrust setpoints, ACK/NAKs each command and
// sequences calibration (motor spin-up delay, start strobe, wait for completion).
module cmd_dispatch
  import quad_cmd_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic                clk,
  input  logic                rst,
  cmd_dispatch_if.slave       bus,
  input  logic                cal_done_i,
  output logic signed [15:0]  d_ptch_o,
  output logic signed [15:0]  d_roll_o,
  output logic signed [15:0]  d_yaw_o,
  output logic [8:0]          thrst_o,
  output logic                strt_cal_o,
  output logic                inertial_cal_o,
  output logic                motors_off_o
);

  localparam int TMR_W = (FAST_SIM != 0) ? 9 : 26;

  disp_state_t        state_q, state_d;
  logic signed [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
  logic [8:0]         thrst_q, thrst_d;
  logic               moff_q, moff_d;
  logic               tmr_clr, tmr_en, tmr_full;
  logic               clr, send, strt, inert;
  logic [7:0]         resp;

  cal_tmr #(.W(TMR_W)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .full_o (tmr_full)
  );

  // State and setpoint registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptch_q  <= 16'sd0;
      roll_q  <= 16'sd0;
      yaw_q   <= 16'sd0;
      thrst_q <= 9'd0;
      moff_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptch_q  <= ptch_d;
      roll_q  <= roll_d;
      yaw_q   <= yaw_d;
      thrst_q <= thrst_d;
      moff_q  <= moff_d;
    end
  end

  // Next state, setpoint updates and combinational pulses.
  always_comb begin
    state_d = state_q;
    ptch_d  = ptch_q;
    roll_d  = roll_q;
    yaw_d   = yaw_q;
    thrst_d = thrst_q;
    moff_d  = moff_q;
    clr     = 1'b0;
    send    = 1'b0;
    resp    = 8'h00;
    strt    = 1'b0;
    inert   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_rdy) begin
          clr  = 1'b1;
          send = 1'b1;
          resp = RESP_ACK;
          case (bus.cmd)
            SET_PITCH:  ptch_d  = bus.data;
            SET_ROLL:   roll_d  = bus.data;
            SET_YAW:    yaw_d   = bus.data;
            SET_THRST:  thrst_d = bus.data[8:0];
            E_LAND: begin
              ptch_d  = 16'sd0;
              roll_d  = 16'sd0;
              yaw_d   = 16'sd0;
              thrst_d = 9'd0;
            end
            MOTORS_OFF: moff_d  = 1'b1;
            CALIBRATE: begin
              // The ACK for calibration is deferred until cal_done.
              send    = 1'b0;
              inert   = 1'b1;
              tmr_clr = 1'b1;
              moff_d  = 1'b0;
              state_d = SPINUP;
            end
            default:    resp    = RESP_NAK;
          endcase
        end else begin
          clr = 1'b0;
        end
      end
      SPINUP: begin
        inert = 1'b1;
        if (tmr_full) begin
          strt    = 1'b1;
          state_d = CAL;
        end else begin
          tmr_en  = 1'b1;
        end
      end
      CAL: begin
        inert = 1'b1;
        if (cal_done_i) begin
          send    = 1'b1;
          resp    = RESP_ACK;
          state_d = IDLE;
        end else begin
          state_d = CAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.clr_cmd_rdy = clr;
  assign bus.send_resp   = send;
  assign bus.resp        = resp;
  assign strt_cal_o      = strt;
  assign inertial_cal_o  = inert;
  assign d_ptch_o        = ptch_q;
  assign d_roll_o        = roll_q;
  assign d_yaw_o         = yaw_q;
  assign thrst_o         = thrst_q;
  assign motors_off_o    = moff_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: directed test-plan steps plus random setpoint traffic
// checked against a simple register-file model of the command rules.
module tb_cmd_dispatch;
  import quad_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cal_done = 1'b0;
  logic signed [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0] thrst;
  logic strt_cal, inertial_cal, motors_off;

  cmd_dispatch_if bus();

  cmd_dispatch #(.FAST_SIM(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cal_done_i     (cal_done),
    .d_ptch_o       (d_ptch),
    .d_roll_o       (d_roll),
    .d_yaw_o        (d_yaw),
    .thrst_o        (thrst),
    .strt_cal_o     (strt_cal),
    .inertial_cal_o (inertial_cal),
    .motors_off_o   (motors_off)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_ptch, m_roll, m_yaw;
  logic [8:0]  m_thrst;
  logic        m_moff;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] regs_dut();
    return {6'b0, d_ptch, d_roll, d_yaw, thrst, motors_off};
  endfunction

  function automatic logic [63:0] regs_model();
    return {6'b0, m_ptch, m_roll, m_yaw, m_thrst, m_moff};
  endfunction

  task automatic model_reset();
    m_ptch = 16'h0; m_roll = 16'h0; m_yaw = 16'h0; m_thrst = 9'h0; m_moff = 1'b1;
  endtask

  task automatic model_apply(input logic [7:0] op, input logic [15:0] d);
    case (op)
      8'h02: m_ptch = d;
      8'h03: m_roll = d;
      8'h04: m_yaw = d;
      8'h05: m_thrst = d[8:0];
      8'h06: m_moff = 1'b0;
      8'h07: begin m_ptch = 16'h0; m_roll = 16'h0; m_yaw = 16'h0; m_thrst = 9'h0; end
      8'h08: m_moff = 1'b1;
      default: ;
    endcase
  endtask

  function automatic logic [7:0] exp_resp(input logic [7:0] op);
    return (op >= 8'h02 && op <= 8'h08 && op != 8'h06) ? 8'hA5 : 8'hEE;
  endfunction

  // One non-calibrate command through the handshake, checked before and after its edge.
  task automatic issue(input string tag, input logic [7:0] op, input logic [15:0] d);
    @(negedge clk);
    bus.cmd_rdy = 1'b1; bus.cmd = op; bus.data = d;
    #1;
    check({tag, ".clr"}, 64'(bus.clr_cmd_rdy), 64'd1);
    check({tag, ".send"}, 64'(bus.send_resp), 64'd1);
    check({tag, ".resp"}, 64'(bus.resp), 64'(exp_resp(op)));
    check({tag, ".ical"}, 64'(inertial_cal), 64'd0);
    @(posedge clk);
    #1;
    bus.cmd_rdy = 1'b0;
    model_apply(op, d);
    #1;
    check({tag, ".clr_off"}, 64'(bus.clr_cmd_rdy), 64'd0);
    check({tag, ".send_off"}, 64'(bus.send_resp), 64'd0);
    check({tag, ".regs"}, regs_dut(), regs_model());
  endtask

  initial begin
    int strt_n;
    int strt_cnt;
    logic [15:0] pend_d;
    logic [7:0] op;
    logic [7:0] ops [6];
    ops = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08};
    bus.cmd_rdy = 1'b0; bus.cmd = 8'h00; bus.data = 16'h0000;
    model_reset();

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.regs", regs_dut(), regs_model());
    check("rst.clr", 64'(bus.clr_cmd_rdy), 64'd0);
    check("rst.send", 64'(bus.send_resp), 64'd0);
    check("rst.strt", 64'(strt_cal), 64'd0);
    check("rst.ical", 64'(inertial_cal), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("thrst", 8'h05, 16'hFFAA);
    check("thrst.val", 64'(thrst), 64'h1AA);
    issue("pitch", 8'h02, 16'h00AA);
    issue("yaw", 8'h04, 16'h0099);
    issue("roll", 8'h03, 16'hFF9A);
    check("att.vals", {16'h0, d_ptch, d_yaw, d_roll}, {16'h0, 16'd170, 16'd153, 16'hFF9A});

    // Calibrate with a SET_PITCH arriving during spin-up.
    pend_d = 16'($urandom);
    @(negedge clk);
    bus.cmd_rdy = 1'b1; bus.cmd = 8'h06; bus.data = 16'h0000;
    #1;
    check("cal.ical", 64'(inertial_cal), 64'd1);
    check("cal.clr", 64'(bus.clr_cmd_rdy), 64'd1);
    check("cal.send", 64'(bus.send_resp), 64'd0);
    check("cal.strt", 64'(strt_cal), 64'd0);
    @(posedge clk);
    #1;
    bus.cmd_rdy = 1'b0;
    model_apply(8'h06, 16'h0000);
    #1;
    check("cal.regs", regs_dut(), regs_model());
    strt_n = 0; strt_cnt = 0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == 10) begin
        bus.cmd_rdy = 1'b1; bus.cmd = 8'h02; bus.data = pend_d;
      end
      #1;
      if (n == 10 || n == 300 || n == 600) begin
        check("spin.hold_clr", 64'(bus.clr_cmd_rdy), 64'd0);
        check("spin.ical", 64'(inertial_cal), 64'd1);
      end
      if (strt_cal) begin
        strt_cnt++;
        strt_n = n;
      end
    end
    check("cal.strt_lat", 64'(strt_n), 64'd512);
    check("cal.strt_cnt", 64'(strt_cnt), 64'd1);
    @(negedge clk);
    cal_done = 1'b1;
    #1;
    check("done.send", 64'(bus.send_resp), 64'd1);
    check("done.resp", 64'(bus.resp), 64'hA5);
    check("done.clr", 64'(bus.clr_cmd_rdy), 64'd0);
    @(posedge clk);
    #1;
    cal_done = 1'b0;
    #1;
    check("done.regs", regs_dut(), regs_model());
    // Pending SET_PITCH is serviced in the first IDLE cycle.
    @(negedge clk);
    #1;
    check("pend.clr", 64'(bus.clr_cmd_rdy), 64'd1);
    check("pend.send", 64'(bus.send_resp), 64'd1);
    check("pend.resp", 64'(bus.resp), 64'hA5);
    check("pend.ical", 64'(inertial_cal), 64'd0);
    @(posedge clk);
    #1;
    bus.cmd_rdy = 1'b0;
    model_apply(8'h02, pend_d);
    #1;
    check("pend.regs", regs_dut(), regs_model());

    issue("eland", 8'h07, 16'($urandom));
    issue("moff", 8'h08, 16'($urandom));
    issue("illegal", 8'h1F, 16'h1234);

    // Random legal and illegal commands.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 8'($urandom_range(9, 255));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      issue("rand", op, 16'($urandom));
    end

    // Reset while in CAL: no ACK, back to reset values.
    @(negedge clk);
    bus.cmd_rdy = 1'b1; bus.cmd = 8'h06;
    @(posedge clk);
    #1;
    bus.cmd_rdy = 1'b0;
    model_apply(8'h06, 16'h0000);
    repeat (520) @(negedge clk);
    #1;
    check("rcal.in_cal", 64'(inertial_cal), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    cal_done = 1'b1;
    model_reset();
    #1;
    check("rcal.send", 64'(bus.send_resp), 64'd0);
    check("rcal.ical", 64'(inertial_cal), 64'd0);
    check("rcal.regs", regs_dut(), regs_model());
    @(negedge clk);
    rst = 1'b0;
    cal_done = 1'b0;
    #1;
    check("rcal.post_send", 64'(bus.send_resp), 64'd0);
    check("rcal.post_ical", 64'(inertial_cal), 64'd0);
    issue("post_rst", 8'h05, 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
